// File: rtl/spi_dac_rx.sv
// spi_dac_rx: SPI slave receiver for the 16-bit DAC command frame.
// Oversamples n_CS/SCK/SDI in the clk domain and shifts one word per
// chip-select window. On n_CS deassertion the frame is either published as
// word/cfg/data with a one-cycle strobe, or rejected with an error pulse.
module spi_dac_rx #(
  parameter int WORD_BITS   = 16,
  parameter int CFG_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          n_CS,
  input  logic                          SCK,
  input  logic                          SDI,
  output logic [WORD_BITS-1:0]          word_out,
  output logic [CFG_BITS-1:0]           cfg_out,
  output logic [WORD_BITS-CFG_BITS-1:0] data_out,
  output logic                          word_valid,
  output logic                          frame_err,
  output logic [7:0]                    err_count,
  output logic                          busy
);

  // Counter doubles as the bit counter (SHIFT) and the settle counter
  // (WAIT_HIGH), so it must cover both WORD_BITS+1 and SYNC_STAGES.
  localparam int CNT_TOP = (WORD_BITS + 1 > SYNC_STAGES) ? WORD_BITS + 1 : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic                   word_valid_q, word_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [7:0]             err_count_q, err_count_d;

  logic cs_s, sck_s, sdi_s;
  logic cs_rise, cs_fall, sck_rise, sck_take;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;
  // SCK edges only count while the synchronized chip select is low.
  assign sck_take = sck_rise & ~cs_s;

  // Synchronizer chains and edge-detect history for the three pins.
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], n_CS};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], SDI};
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
  end

  // Frame FSM: settle after reset, wait for chip select, shift, close frame.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;

    case (state_q)
      WAIT_HIGH: begin
        // cs_s must stay high long enough that the value comes from the pin,
        // not from the reset preload of the synchronizer.
        if (!cs_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_SETTLE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          if (sck_take) begin
            shift_d = {{(WORD_BITS-1){1'b0}}, sdi_s};
            cnt_d   = CNT_W'(1);
          end
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            word_d       = shift_q;
            word_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end
        end else if (sck_take) begin
          shift_d = {shift_q[WORD_BITS-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = WAIT_HIGH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!n_rst) begin
      cs_sync_q    <= '1;
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      cs_prev_q    <= 1'b1;
      sck_prev_q   <= 1'b0;
      state_q      <= WAIT_HIGH;
      shift_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      sck_sync_q   <= sck_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      cs_prev_q    <= cs_prev_d;
      sck_prev_q   <= sck_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign word_out   = word_q;
  assign cfg_out    = word_q[WORD_BITS-1 -: CFG_BITS];
  assign data_out   = word_q[WORD_BITS-CFG_BITS-1:0];
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: directed SPI master driving spi_dac_rx, with a scoreboard
// of expected frame-close events checked by a pulse monitor.
module tb_spi_dac_rx;

  localparam int H   = 6;  // clk periods per SCK phase
  localparam int GAP = 4;  // minimum n_CS high time (SYNC_STAGES+2)

  logic        clk = 1'b0;
  logic        n_rst, n_CS, SCK, SDI;
  logic [15:0] word_out;
  logic [3:0]  cfg_out;
  logic [11:0] data_out;
  logic        word_valid, frame_err, busy;
  logic [7:0]  err_count;

  typedef struct {
    bit          is_err;
    logic [15:0] word;
    logic [7:0]  errs;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_word;
  logic [7:0]  m_err;
  int          compared   = 0;
  int          mismatched = 0;

  spi_dac_rx #(.WORD_BITS(16), .CFG_BITS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .n_rst(n_rst), .n_CS(n_CS), .SCK(SCK), .SDI(SDI),
    .word_out(word_out), .cfg_out(cfg_out), .data_out(data_out),
    .word_valid(word_valid), .frame_err(frame_err),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (n_rst && (word_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(word_valid) << 1 | 32'(frame_err), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_err", 32'(frame_err), 32'(e.is_err));
        check("word_valid", 32'(word_valid), 32'(!e.is_err));
        check("word_out", 32'(word_out), 32'(e.word));
        check("cfg_out", 32'(cfg_out), 32'(e.word >> 12));
        check("data_out", 32'(data_out), 32'(e.word & 16'h0FFF));
        check("err_count", 32'(err_count), 32'(e.errs));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic begin_frame();
    @(negedge clk);
    n_CS = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SDI = v[i];
      repeat (H) @(negedge clk);
      SCK = 1'b1;
      repeat (H) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  // Raise n_CS; optionally queue the expected close event and check latency.
  task automatic end_frame(input int n, input logic [31:0] v, input bit push, input bit lat);
    exp_t e;
    repeat (H) @(negedge clk);
    n_CS = 1'b1;
    if (push) begin
      if (n == 16) begin
        m_word = v[15:0];
        e.is_err = 1'b0;
      end else begin
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        e.is_err = 1'b1;
      end
      e.word = m_word;
      e.errs = m_err;
      sb.push_back(e);
    end
    if (lat) begin
      @(posedge clk);           // edge k
      @(posedge clk); #1;       // edge k+1
      check("lat_k1_low", 32'(word_valid), 32'd0);
      @(posedge clk); #1;       // edge k+2
      check("lat_k2_high", 32'(word_valid), 32'd1);
      @(posedge clk); #1;       // edge k+3
      check("lat_k3_low", 32'(word_valid), 32'd0);
    end
    repeat (GAP) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    begin_frame();
    send_bits(v, n);
    end_frame(n, v, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; n_CS = 1'b1; SCK = 1'b0; SDI = 1'b0;
    m_word = '0; m_err = '0;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_word", 32'(word_out), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", {30'd0, word_valid, frame_err}, 32'd0);
    repeat (10) @(negedge clk);

    // Nominal frame with latency check.
    begin_frame();
    send_bits(32'hC780, 16);
    check("busy_in_frame", 32'(busy), 32'd1);
    end_frame(16, 32'hC780, 1'b1, 1'b1);
    drain("drain_c780");
    check("idle_busy", 32'(busy), 32'd0);

    // Short frame, then overrun frame, then a good frame.
    frame(32'h3FF, 12);
    drain("drain_short");
    check("hold_word_short", 32'(word_out), 32'hC780);
    frame(32'hAAAA5, 20);
    frame(32'h1234, 16);
    drain("drain_overrun");

    // Reset mid-frame: the in-flight frame must vanish silently.
    begin_frame();
    send_bits(32'hFF, 8);
    @(negedge clk); n_rst = 1'b0;
    repeat (3) @(negedge clk); n_rst = 1'b1;
    m_word = '0; m_err = '0;
    check("midrst_word", 32'(word_out), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    send_bits(32'hFF, 8);
    end_frame(16, 32'hFFFF, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("midrst_no_strobe_err", 32'(err_count), 32'd0);
    frame(32'h5A5A, 16);
    drain("drain_5a5a");

    // Back-to-back frames with minimum gap, then a zero-length frame.
    frame(32'h0001, 16);
    frame(32'hFFFE, 16);
    begin_frame();
    end_frame(0, 32'd0, 1'b1, 1'b0);
    drain("drain_b2b_zero");

    // Error counter saturation.
    for (int i = 0; i < 260; i++) frame(32'h1, 1);
    drain("drain_sat");
    check("err_count_sat", 32'(err_count), 32'd255);
    check("word_after_sat", 32'(word_out), 32'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
